// File: rtl/uart_image_loader_if.sv
// -----------------------------------------------------------------------------
// uart_image_loader_if
//   Frame-buffer write bus shared by the left and right image BRAMs.
//   master : driven by uart_image_loader
//   slave  : BRAM side (write-only port, always accepts)
//   wr_addr_out  word address, common to both images
//   wr_data_out  six packed 8-bit pixels, first pixel in [47:40]
//   left_we_out  one-cycle write strobe, left BRAM
//   right_we_out one-cycle write strobe, right BRAM
// -----------------------------------------------------------------------------
interface uart_image_loader_if #(
    parameter int ADDR_W = 14
) ();
    logic [ADDR_W-1:0] wr_addr_out;
    logic [47:0]       wr_data_out;
    logic              left_we_out;
    logic              right_we_out;

    modport master (output wr_addr_out, wr_data_out, left_we_out, right_we_out);
    modport slave  (input  wr_addr_out, wr_data_out, left_we_out, right_we_out);
endinterface

// File: rtl/uart_image_loader.sv
// -----------------------------------------------------------------------------
// uart_image_loader
//   Receives a stereo image pair over an 8N1 UART (sync byte, left image,
//   right image) and writes it six pixels per 48-bit word into the left and
//   right frame-buffer BRAMs.
//
//   Ports
//     clk_in          system clock
//     rst_in          asynchronous active-low reset
//     uart_rxd        UART receive line, idle high, LSB first
//     wr_if           BRAM write bus (master modport)
//     busy_out        high from sync byte accepted until frame end or abort
//     frame_done_out  one-cycle pulse once the pair is fully written
//     error_out       sticky framing / checksum error, cleared by next sync
//
//   Optional feature: define UART_IMAGE_LOADER_CHECKSUM_EN to require a
//   trailing XOR-of-all-pixels byte before frame_done_out is pulsed.
// -----------------------------------------------------------------------------
module uart_image_loader #(
    parameter int         CLK_FREQ        = 100000000,
    parameter int         BAUD_RATE       = 3000000,
    parameter int         WORDS_PER_IMAGE = 12800,
    parameter logic [7:0] SYNC_BYTE       = 8'hA5
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 uart_rxd,
    uart_image_loader_if.master  wr_if,
    output logic                 busy_out,
    output logic                 frame_done_out,
    output logic                 error_out
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
    localparam int ADDR_W       = $clog2(WORDS_PER_IMAGE);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS_PER_IMAGE - 1);

    // ------------------------------------------------------------------ RX
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    logic       rx_s1_q, rx_s2_q, rx_prev_q;
    rx_state_t  rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0] rx_bit_q, rx_bit_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic       byte_valid, frame_err;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_s1_q    <= uart_rxd;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 1'b1;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                // Edge, not level: after a framing error the line may still
                // be low and must not be taken as a new start bit.
                if (rx_prev_q && !rx_s2_q) rx_state_d = RX_START;
            end
            RX_START: begin
                if (rx_cnt_q == CNT_W'(HALF_BIT - 1)) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    // High at mid start bit: glitch, drop it.
                    rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                    rx_state_d = RX_IDLE;
                    if (rx_s2_q) byte_valid = 1'b1;
                    else         frame_err  = 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // -------------------------------------------------------------- loader
    typedef enum logic [2:0] {
        WAIT_SYNC,
        LOAD_LEFT,
        LOAD_RIGHT,
`ifdef UART_IMAGE_LOADER_CHECKSUM_EN
        CHECK,
`endif
        DONE
    } ld_state_t;

`ifdef UART_IMAGE_LOADER_CHECKSUM_EN
    localparam ld_state_t AFTER_RIGHT = CHECK;
`else
    localparam ld_state_t AFTER_RIGHT = DONE;
`endif

    ld_state_t         st_q, st_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;   // next word to be written
    logic [2:0]        cnt_q, cnt_d;       // bytes already in pack_q
    logic [39:0]       pack_q, pack_d;
    logic [7:0]        csum_q, csum_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [47:0]       data_q, data_d;
    logic              lwe_q, lwe_d, rwe_q, rwe_d;
    logic              busy_q, busy_d, done_q, done_d, err_q, err_d;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            st_q    <= WAIT_SYNC;
            waddr_q <= '0;
            cnt_q   <= '0;
            pack_q  <= '0;
            csum_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            lwe_q   <= 1'b0;
            rwe_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            st_q    <= st_d;
            waddr_q <= waddr_d;
            cnt_q   <= cnt_d;
            pack_q  <= pack_d;
            csum_q  <= csum_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            lwe_q   <= lwe_d;
            rwe_q   <= rwe_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        st_d    = st_q;
        waddr_d = waddr_q;
        cnt_d   = cnt_q;
        pack_d  = pack_q;
        csum_d  = csum_q;
        addr_d  = addr_q;
        data_d  = data_q;
        lwe_d   = 1'b0;
        rwe_d   = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        if (frame_err) begin
            st_d   = WAIT_SYNC;
            busy_d = 1'b0;
            err_d  = 1'b1;
        end else begin
            case (st_q)
                WAIT_SYNC: begin
                    if (byte_valid && rx_shift_q == SYNC_BYTE) begin
                        st_d    = LOAD_LEFT;
                        waddr_d = '0;
                        cnt_d   = '0;
                        csum_d  = '0;
                        busy_d  = 1'b1;
                        err_d   = 1'b0;
                    end
                end
                LOAD_LEFT, LOAD_RIGHT: begin
                    if (byte_valid) begin
                        pack_d = {pack_q[31:0], rx_shift_q};
                        csum_d = csum_q ^ rx_shift_q;
                        if (cnt_q == 3'd5) begin
                            cnt_d   = '0;
                            addr_d  = waddr_q;
                            data_d  = {pack_q, rx_shift_q};
                            lwe_d   = (st_q == LOAD_LEFT);
                            rwe_d   = (st_q == LOAD_RIGHT);
                            waddr_d = waddr_q + 1'b1;
                            if (waddr_q == LAST_ADDR) begin
                                waddr_d = '0;
                                st_d    = (st_q == LOAD_LEFT) ? LOAD_RIGHT : AFTER_RIGHT;
                            end
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end
                end
`ifdef UART_IMAGE_LOADER_CHECKSUM_EN
                CHECK: begin
                    if (byte_valid) begin
                        if (rx_shift_q == csum_q) begin
                            st_d = DONE;
                        end else begin
                            st_d   = WAIT_SYNC;
                            busy_d = 1'b0;
                            err_d  = 1'b1;
                        end
                    end
                end
`endif
                DONE: begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                    st_d   = WAIT_SYNC;
                end
                default: st_d = WAIT_SYNC;
            endcase
        end
    end

    assign wr_if.wr_addr_out  = addr_q;
    assign wr_if.wr_data_out  = data_q;
    assign wr_if.left_we_out  = lwe_q;
    assign wr_if.right_we_out = rwe_q;
    assign busy_out           = busy_q;
    assign frame_done_out     = done_q;
    assign error_out          = err_q;
endmodule

// File: tb/tb_uart_image_loader.sv
// -----------------------------------------------------------------------------
// tb_uart_image_loader
//   Small-frame bench (4 words per image, 8 clocks per bit). Frames are
//   built as byte queues; expected BRAM writes are derived from the byte
//   order alone (word k = bytes 6k..6k+5, first byte most significant).
// -----------------------------------------------------------------------------
module tb_uart_image_loader;
    localparam int W        = 4;
    localparam int CPB      = 8;
    localparam int AW       = $clog2(W);
    localparam int NPIX     = 12 * W;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    logic uart_rxd = 1'b1;
    logic busy_out, frame_done_out, error_out;

    uart_image_loader_if #(.ADDR_W(AW)) bus ();

    uart_image_loader #(
        .CLK_FREQ       (80000000),
        .BAUD_RATE      (10000000),
        .WORDS_PER_IMAGE(W),
        .SYNC_BYTE      (8'hA5)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .uart_rxd      (uart_rxd),
        .wr_if         (bus),
        .busy_out      (busy_out),
        .frame_done_out(frame_done_out),
        .error_out     (error_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic          right;
        logic [AW-1:0] addr;
        logic [47:0]   data;
    } wr_t;

    wr_t wq[$];
    int  done_cnt = 0;
    int  both_hi  = 0;
    int  cyc      = 0;
    int  last_wr_cyc = 0;
    int  done_cyc    = 0;
    int  checks   = 0;
    int  failures = 0;
    logic [7:0] pix[$];

    // Passive monitor of the write bus and done pulse.
    always @(negedge clk_in) begin
        cyc = cyc + 1;
        if (bus.left_we_out && bus.right_we_out) both_hi = both_hi + 1;
        if (bus.left_we_out || bus.right_we_out) begin
            wq.push_back('{right: bus.right_we_out, addr: bus.wr_addr_out, data: bus.wr_data_out});
            last_wr_cyc = cyc;
        end
        if (frame_done_out) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    // ---------------------------------------------------------- model
    function automatic logic [47:0] exp_word(input int k);
        logic [47:0] w;
        w = '0;
        for (int j = 0; j < 6; j++) w = {w[39:0], pix[6*k+j]};
        return w;
    endfunction

    function automatic logic [7:0] exp_csum();
        logic [7:0] c;
        c = 8'h00;
        foreach (pix[i]) c = c ^ pix[i];
        return c;
    endfunction

    // ------------------------------------------------------- stimulus
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk_in); uart_rxd = 1'b0;
        repeat (CPB) @(negedge clk_in);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            repeat (CPB) @(negedge clk_in);
        end
        uart_rxd = stop_bit;
        repeat (CPB) @(negedge clk_in);
        uart_rxd = 1'b1;
        repeat (stop_bit ? 2 : CPB) @(negedge clk_in);
    endtask

    task automatic send_pixels(input int from, input int to);
        for (int k = from; k < to; k++) send_byte(pix[k], 1'b1);
    endtask

    task automatic send_trailer(input logic [7:0] flip);
`ifdef UART_IMAGE_LOADER_CHECKSUM_EN
        send_byte(exp_csum() ^ flip, 1'b1);
`endif
        repeat (4) @(negedge clk_in);
    endtask

    task automatic rand_pixels();
        pix.delete();
        for (int i = 0; i < NPIX; i++) pix.push_back(8'($urandom));
    endtask

    function automatic logic [7:0] rand_non_sync();
        logic [7:0] b;
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h5A;
        return b;
    endfunction

    // ---------------------------------------------------------- tests
    task automatic test_reset();
        rst_in = 1'b0;
        repeat (3) @(negedge clk_in);
        checks++;
        if ({bus.wr_addr_out, bus.wr_data_out} !== '0) begin
            failures++;
            $display("FAIL reset_bus addr=%h data=%h required 0", bus.wr_addr_out, bus.wr_data_out);
        end
        checks++;
        if ({bus.left_we_out, bus.right_we_out} !== 2'b00) begin
            failures++;
            $display("FAIL reset_we got=%b required 00", {bus.left_we_out, bus.right_we_out});
        end
        checks++;
        if ({busy_out, frame_done_out, error_out} !== 3'b000) begin
            failures++;
            $display("FAIL reset_status got=%b required 000", {busy_out, frame_done_out, error_out});
        end
        rst_in = 1'b1;
        repeat (3) @(negedge clk_in);
    endtask

    task automatic test_glitch();
        int wb;
        wb = wq.size();
        @(negedge clk_in); uart_rxd = 1'b0;
        repeat (2) @(negedge clk_in);
        uart_rxd = 1'b1;
        repeat (10 * CPB) @(negedge clk_in);
        checks++;
        if (wq.size() !== wb || busy_out !== 1'b0 || error_out !== 1'b0) begin
            failures++;
            $display("FAIL glitch writes=%0d busy=%b err=%b required 0/0/0", wq.size() - wb, busy_out, error_out);
        end
    endtask

    task automatic test_small_frame();
        int wb, db;
        pix.delete();
        for (int i = 0; i < NPIX; i++) pix.push_back(8'(i));
        wb = wq.size(); db = done_cnt;
        send_byte(8'hA5, 1'b1);
        send_pixels(0, NPIX);
        send_trailer(8'h00);
        checks++;
        if (wq.size() - wb !== 2 * W) begin
            failures++;
            $display("FAIL small_count got=%0d required %0d", wq.size() - wb, 2 * W);
        end
        for (int k = 0; k < 2 * W && wb + k < wq.size(); k++) begin
            checks++;
            if (wq[wb+k].right !== (k >= W) || wq[wb+k].addr !== AW'(k % W) || wq[wb+k].data !== exp_word(k)) begin
                failures++;
                $display("FAIL small_word%0d got r=%b a=%0d d=%h required r=%b a=%0d d=%h", k,
                         wq[wb+k].right, wq[wb+k].addr, wq[wb+k].data, k >= W, k % W, exp_word(k));
            end
        end
        checks++;
        if (done_cnt - db !== 1) begin
            failures++;
            $display("FAIL small_done got=%0d pulses required 1", done_cnt - db);
        end
`ifndef UART_IMAGE_LOADER_CHECKSUM_EN
        checks++;
        if (done_cyc - last_wr_cyc !== 1) begin
            failures++;
            $display("FAIL small_done_lat got=%0d required 1", done_cyc - last_wr_cyc);
        end
`endif
        checks++;
        if (busy_out !== 1'b0 || error_out !== 1'b0 || both_hi !== 0) begin
            failures++;
            $display("FAIL small_status busy=%b err=%b both=%0d required 0/0/0", busy_out, error_out, both_hi);
        end
    endtask

    task automatic test_noise_sync();
        int wb, db;
        logic [7:0] noise[$];
        noise = '{8'h00, 8'hFF, 8'h3C};
        for (int i = 0; i < 3; i++) noise.push_back(rand_non_sync());
        rand_pixels();
        wb = wq.size(); db = done_cnt;
        foreach (noise[i]) send_byte(noise[i], 1'b1);
        checks++;
        if (wq.size() !== wb || busy_out !== 1'b0) begin
            failures++;
            $display("FAIL noise_idle writes=%0d busy=%b required 0/0", wq.size() - wb, busy_out);
        end
        send_byte(8'hA5, 1'b1);
        checks++;
        if (busy_out !== 1'b1) begin
            failures++;
            $display("FAIL noise_busy got=%b required 1", busy_out);
        end
        send_pixels(0, NPIX);
        send_trailer(8'h00);
        checks++;
        if (wq.size() - wb !== 2 * W || done_cnt - db !== 1) begin
            failures++;
            $display("FAIL noise_frame writes=%0d done=%0d required %0d/1", wq.size() - wb, done_cnt - db, 2 * W);
        end
        for (int k = 0; k < 2 * W && wb + k < wq.size(); k++) begin
            checks++;
            if (wq[wb+k].right !== (k >= W) || wq[wb+k].addr !== AW'(k % W) || wq[wb+k].data !== exp_word(k)) begin
                failures++;
                $display("FAIL noise_word%0d got d=%h required d=%h", k, wq[wb+k].data, exp_word(k));
            end
        end
    endtask

`ifdef UART_IMAGE_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        int db;
        rand_pixels();
        db = done_cnt;
        send_byte(8'hA5, 1'b1);
        send_pixels(0, NPIX);
        send_trailer(8'h00);
        checks++;
        if (done_cnt - db !== 1 || error_out !== 1'b0) begin
            failures++;
            $display("FAIL csum_good done=%0d err=%b required 1/0", done_cnt - db, error_out);
        end
        db = done_cnt;
        send_byte(8'hA5, 1'b1);
        send_pixels(0, NPIX);
        send_trailer(8'h01);
        checks++;
        if (done_cnt - db !== 0 || error_out !== 1'b1 || busy_out !== 1'b0) begin
            failures++;
            $display("FAIL csum_bad done=%0d err=%b busy=%b required 0/1/0", done_cnt - db, error_out, busy_out);
        end
    endtask
`endif

    task automatic test_framing_error();
        int wb, db;
        rand_pixels();
        wb = wq.size(); db = done_cnt;
        send_byte(8'hA5, 1'b1);
        send_pixels(0, 6);
        send_byte(pix[6], 1'b0);
        checks++;
        if (error_out !== 1'b1 || busy_out !== 1'b0) begin
            failures++;
            $display("FAIL ferr_status err=%b busy=%b required 1/0", error_out, busy_out);
        end
        checks++;
        if (wq.size() - wb !== 1) begin
            failures++;
            $display("FAIL ferr_count got=%0d required 1", wq.size() - wb);
        end else begin
            checks++;
            if (wq[wb].right !== 1'b0 || wq[wb].addr !== '0 || wq[wb].data !== exp_word(0)) begin
                failures++;
                $display("FAIL ferr_word0 got d=%h required d=%h", wq[wb].data, exp_word(0));
            end
        end
        for (int i = 0; i < 4; i++) send_byte(rand_non_sync(), 1'b1);
        checks++;
        if (wq.size() - wb !== 1 || done_cnt - db !== 0) begin
            failures++;
            $display("FAIL ferr_after writes=%0d done=%0d required 1/0", wq.size() - wb, done_cnt - db);
        end
        send_byte(8'hA5, 1'b1);
        checks++;
        if (error_out !== 1'b0 || busy_out !== 1'b1) begin
            failures++;
            $display("FAIL ferr_resync err=%b busy=%b required 0/1", error_out, busy_out);
        end
    endtask

    task automatic test_reset_mid();
        int wb, db;
        @(negedge clk_in); rst_in = 1'b0;
        repeat (2) @(negedge clk_in); rst_in = 1'b1;
        repeat (2) @(negedge clk_in);
        rand_pixels();
        send_byte(8'hA5, 1'b1);
        send_pixels(0, 6 * W + 12);
        @(negedge clk_in); #2 rst_in = 1'b0;
        #1;
        checks++;
        if ({bus.wr_addr_out, bus.wr_data_out, bus.left_we_out, bus.right_we_out,
             busy_out, frame_done_out, error_out} !== '0) begin
            failures++;
            $display("FAIL rstmid_outputs addr=%h data=%h busy=%b required all 0",
                     bus.wr_addr_out, bus.wr_data_out, busy_out);
        end
        repeat (3) @(negedge clk_in);
        rst_in = 1'b1;
        repeat (3) @(negedge clk_in);
        rand_pixels();
        wb = wq.size(); db = done_cnt;
        send_byte(8'hA5, 1'b1);
        send_pixels(0, NPIX);
        send_trailer(8'h00);
        checks++;
        if (wq.size() - wb !== 2 * W || done_cnt - db !== 1) begin
            failures++;
            $display("FAIL rstmid_frame writes=%0d done=%0d required %0d/1", wq.size() - wb, done_cnt - db, 2 * W);
        end
        for (int k = 0; k < 2 * W && wb + k < wq.size(); k++) begin
            checks++;
            if (wq[wb+k].right !== (k >= W) || wq[wb+k].addr !== AW'(k % W) || wq[wb+k].data !== exp_word(k)) begin
                failures++;
                $display("FAIL rstmid_word%0d got r=%b a=%0d d=%h required r=%b a=%0d d=%h", k,
                         wq[wb+k].right, wq[wb+k].addr, wq[wb+k].data, k >= W, k % W, exp_word(k));
            end
        end
        checks++;
        if (both_hi !== 0) begin
            failures++;
            $display("FAIL we_exclusive got=%0d overlaps required 0", both_hi);
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_small_frame();
        test_noise_sync();
`ifdef UART_IMAGE_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_framing_error();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_image_loader.md
# uart_image_loader

Receives a stereo image pair over UART and writes it, packed six 8-bit pixels per 48-bit word, into the left and right frame-buffer BRAMs that feed the disparity engine. It is the inbound counterpart of the disparity readout path: the host streams a sync byte, the left image and then the right image. When both images are stored, the block pulses `frame_done_out`, which drives the engine's new-frame start.

## Interface
- `CLK_FREQ`, 100000000, system clock in Hz
- `BAUD_RATE`, 3000000, UART bit rate; `CLKS_PER_BIT = CLK_FREQ/BAUD_RATE` (integer division, 33 at defaults)
- `WORDS_PER_IMAGE`, 12800, 48-bit words per image (320 rows x 40 words)
- `SYNC_BYTE`, 8'hA5, frame start marker
- `clk_in`  input  1  system clock
- `rst_in`  input  1  reset, asynchronous and active-low
- `uart_rxd`  input  1  UART receive line, idle high, 8N1, LSB first
- `wr_addr_out`  output  $clog2(WORDS_PER_IMAGE)  BRAM word address, shared by both images
- `wr_data_out`  output  48  packed word
- `left_we_out`  output  1  write strobe, left BRAM
- `right_we_out`  output  1  write strobe, right BRAM
- `busy_out`  output  1  high from sync byte accepted until frame end or abort
- `frame_done_out`  output  1  one-cycle pulse, pair fully written
- `error_out`  output  1  sticky; set on framing error or checksum mismatch

## Operation
- Receiver: `uart_rxd` passes through a 2-flop synchronizer.
  - Falling edge starts a bit; the line is sampled at `CLKS_PER_BIT/2`. If it is high there, the edge was a glitch and the receiver returns to idle.
  - Data bits are sampled every `CLKS_PER_BIT` cycles after that.
  - The stop bit is sampled at its midpoint. High produces a one-cycle internal `byte_valid`; low is a framing error, and the byte is discarded.
- Loader FSM states: WAIT_SYNC, LOAD_LEFT, LOAD_RIGHT, (CHECK), DONE.
  - WAIT_SYNC: bytes other than `SYNC_BYTE` are ignored. `SYNC_BYTE` leads to LOAD_LEFT with address=0, pixel count=0, `busy_out`=1, and clears `error_out`.
  - LOAD_LEFT/RIGHT: each byte shifts into the pack register. The first byte of a word lands in [47:40] and the sixth in [7:0].
  - On the sixth byte, the word is written at the current address and the address increments.
  - After word `WORDS_PER_IMAGE-1` of the left image is written, the address wraps to 0 and the FSM enters LOAD_RIGHT.
  - After the last right word, the FSM goes to CHECK if enabled, otherwise DONE.
  - DONE: pulses `frame_done_out` and drops `busy_out` on the same cycle, then returns to WAIT_SYNC.
- Framing error in any state: sets `error_out`, returns to WAIT_SYNC, drops `busy_out`, and does not pulse `frame_done_out`. Words already written remain in the BRAM.
- `SYNC_BYTE` values arriving mid-frame are treated as pixel data, not resync.
- Reset mid-frame: all state clears immediately, and any write in progress is not issued.

## Timing
- Reset values: `wr_addr_out`=0, `wr_data_out`=0, `left_we_out`=0, `right_we_out`=0, `busy_out`=0, `frame_done_out`=0, `error_out`=0.
- `byte_valid` at cycle N for the sixth byte of a word:
  - Cycle N+1: the write enable is high for exactly one cycle, with `wr_addr_out`/`wr_data_out` valid on that same cycle.
- Last right word written at cycle M: `frame_done_out` at M+1 (no checksum).
- At most one write per 6 byte times, so no back-pressure is needed. The BRAM port is write-only and always accepts.
- `left_we_out` and `right_we_out` are never high together.
- Per-byte time is 10·`CLKS_PER_BIT` cycles; a frame takes about 153601 bytes.

## Configuration
- Macro `UART_IMAGE_LOADER_CHECKSUM_EN`.
- Defined:
  - After the last right word, the FSM enters CHECK and waits for one extra byte.
  - That byte must equal the XOR of all 2·6·`WORDS_PER_IMAGE` pixel bytes.
  - Match: DONE on the next cycle.
  - Mismatch: `error_out`=1, no `frame_done_out`, return to WAIT_SYNC.
- Undefined: no CHECK state and no checksum byte; DONE follows the last right write directly.

## Test plan
- Small-frame load (`WORDS_PER_IMAGE`=4, `CLKS_PER_BIT`=8): send A5, bytes 00..17 left, 18..2F right.
  - Left writes: addr 0 = 48'h000102030405 through addr 3 = 48'h12131415_1617.
  - Right writes: addr 0 = 48'h18191A1B1C1D through addr 3.
  - One `frame_done_out` pulse one cycle after the last right write.
- Noise before sync: send 00, FF, 3C, then A5 and a frame.
  - No writes occur before A5.
  - `busy_out` rises only after A5 is received.
- Framing error: stop bit forced low on byte 7 of the left image.
  - `error_out`=1 and `busy_out`=0.
  - Word 0 is written; no further writes and no `frame_done_out`.
  - The next A5 clears `error_out`.
- Start glitch: a low pulse of 2 cycles on idle line produces no byte, no write, and no error.
- Async reset: assert `rst_in`=0 mid-right-image.
  - All outputs return to zero immediately.
  - After release, a full new frame loads correctly starting at addr 0.
- Checksum (macro defined): a correct XOR byte gives `frame_done_out`; the XOR byte ^ 8'h01 gives `error_out`=1 and no done pulse.
